// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: steps the select of an 8:1 single-bit mux through the enabled
//   channels in ascending order, holds each select DWELL cycles, and captures F
//   into a parallel byte on the last cycle of each dwell.
// Latency: k enabled channels -> done pulses k*DWELL cycles after the accepting edge;
//   an empty mask pulses done on the cycle right after the accepting edge.
// Backpressure: none; start is only looked at while idle and is dropped while busy.
//
// Ports:
//   clk, rst   - system clock (rising edge), asynchronous active-high reset
//   start      - scan request, accepted only in IDLE
//   en_mask    - channel enables (bit n = channel n), latched on an accepted start
//   F          - output of the mux under control
//   S          - registered select driven to the mux
//   busy/done  - scan in progress / one-cycle completion pulse
//   data/valid - captured bits (unscanned bits 0) / capture complete and stable
module mux8_scan_ctrl #(
  parameter int DWELL = 2,  // cycles per channel, 1..15
  parameter int CNT_W = 4   // must be wide enough to hold DWELL-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] en_mask,
  input  logic       F,
  output logic [2:0] S,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mask,  w_mask_nxt;
  logic [7:0]       r_data,  w_data_nxt;
  logic [2:0]       r_sel,   w_sel_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_valid, w_valid_nxt;

  logic [7:0] w_above;     // enabled channels strictly above the current select
  logic [2:0] w_first_idx; // lowest enabled channel of the incoming mask
  logic [2:0] w_next_idx;  // lowest enabled channel above the current select
  logic       w_last;      // this edge is the sample edge of the current channel

  assign w_above = r_mask & (8'hFE << r_sel);
  assign w_last  = (r_cnt == LAST);

  // Priority encoders: iterate downwards so the lowest set bit wins.
  always_comb begin
    w_first_idx = 3'd0;
    w_next_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (en_mask[i]) w_first_idx = 3'(i);
      if (w_above[i]) w_next_idx  = 3'(i);
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mask  <= 8'h00;
      r_data  <= 8'h00;
      r_sel   <= 3'd0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic. An empty mask completes without leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && (en_mask != 8'h00)) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last && (w_above == 8'h00)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and datapath.
  always_comb begin
    w_mask_nxt  = r_mask;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mask_nxt  = en_mask;
          w_data_nxt  = 8'h00;
          w_valid_nxt = 1'b0;
          if (en_mask == 8'h00) begin
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
          end else begin
            w_busy_nxt = 1'b1;
            w_sel_nxt  = w_first_idx;
            w_cnt_nxt  = '0;
          end
        end
      end
      ST_SCAN: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_data_nxt[r_sel] = F;
          if (w_above != 8'h00) begin
            w_sel_nxt = w_next_idx;
            w_cnt_nxt = '0;
          end else begin
            // Select is left on the last channel once the scan ends.
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign S     = r_sel;
  assign busy  = r_busy;
  assign done  = r_done;
  assign data  = r_data;
  assign valid = r_valid;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl: directed bench for mux8_scan_ctrl (DWELL=2) with a bench-side
//   8:1 mux model driving F = mux_in[S], optionally glitched.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mux8_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] en_mask;
  logic       f_bit;
  logic [2:0] s_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] data_o;
  logic       valid_o;

  logic [7:0] mux_in;
  logic       glitch;
  int         n_tests;
  int         n_fail;
  int         done_cnt;
  int         done_n;

  assign f_bit = mux_in[s_o] ^ glitch;

  mux8_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en_mask (en_mask),
    .F       (f_bit),
    .S       (s_o),
    .busy    (busy_o),
    .done    (done_o),
    .data    (data_o),
    .valid   (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present start for one rising edge; returns on the falling edge after the accept.
  task automatic pulse_start(input logic [7:0] m);
    @(negedge clk);
    en_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_S"},     {5'd0, s_o}, 8'h00);
    chk({tag, "_busy"},  {7'd0, busy_o}, 8'h00);
    chk({tag, "_done"},  {7'd0, done_o}, 8'h00);
    chk({tag, "_valid"}, {7'd0, valid_o}, 8'h00);
    chk({tag, "_data"},  data_o, 8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    en_mask = 8'h00;
    mux_in  = 8'h00;
    glitch  = 1'b0;

    // Reset applied with no clock edge in between: outputs clear immediately.
    #2 rst = 1'b1;
    #1 chk_idle_zero("rst_async");
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk_idle_zero("rst_release");

    // Full scan, I=A5: S steps 0..7 two cycles each, done 16 edges after accept.
    mux_in = 8'hA5;
    pulse_start(8'hFF);
    for (int n = 0; n < 16; n++) begin
      chk("full_S", {5'd0, s_o}, 8'(n / 2));
      chk("full_busy", {7'd0, busy_o}, 8'h01);
      chk("full_done_low", {7'd0, done_o}, 8'h00);
      tick();
    end
    chk("full_done", {7'd0, done_o}, 8'h01);
    chk("full_busy_end", {7'd0, busy_o}, 8'h00);
    chk("full_valid", {7'd0, valid_o}, 8'h01);
    chk("full_data", data_o, 8'hA5);
    chk("full_S_hold", {5'd0, s_o}, 8'h07);
    tick();
    chk("full_done_once", {7'd0, done_o}, 8'h00);
    chk("full_valid_hold", {7'd0, valid_o}, 8'h01);
    chk("full_data_hold", data_o, 8'hA5);

    // Sparse mask 81, I=FF; F glitched low through a non-sample edge.
    mux_in = 8'hFF;
    pulse_start(8'h81);
    chk("sparse_S0a", {5'd0, s_o}, 8'h00);
    chk("sparse_valid_clr", {7'd0, valid_o}, 8'h00);
    chk("sparse_data_clr", data_o, 8'h00);
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    chk("sparse_S0b", {5'd0, s_o}, 8'h00);
    tick();
    chk("sparse_S7a", {5'd0, s_o}, 8'h07);
    tick();
    chk("sparse_S7b", {5'd0, s_o}, 8'h07);
    chk("sparse_done_low", {7'd0, done_o}, 8'h00);
    tick();
    chk("sparse_done", {7'd0, done_o}, 8'h01);
    chk("sparse_busy", {7'd0, busy_o}, 8'h00);
    chk("sparse_data", data_o, 8'h81);
    chk("sparse_valid", {7'd0, valid_o}, 8'h01);

    // Empty mask: done on the next cycle, busy never rises, data cleared.
    pulse_start(8'h00);
    chk("empty_done", {7'd0, done_o}, 8'h01);
    chk("empty_busy", {7'd0, busy_o}, 8'h00);
    chk("empty_valid", {7'd0, valid_o}, 8'h01);
    chk("empty_data", data_o, 8'h00);
    tick();
    chk("empty_done_once", {7'd0, done_o}, 8'h00);
    chk("empty_busy2", {7'd0, busy_o}, 8'h00);
    chk("empty_valid_hold", {7'd0, valid_o}, 8'h01);

    // Start held high: re-accepted on the edge closing the done cycle.
    mux_in = 8'hFF;
    @(negedge clk);
    en_mask = 8'h02;
    start   = 1'b1;
    tick();
    chk("held_S", {5'd0, s_o}, 8'h01);
    chk("held_busy", {7'd0, busy_o}, 8'h01);
    chk("held_valid_clr", {7'd0, valid_o}, 8'h00);
    tick();
    tick();
    chk("held_done1", {7'd0, done_o}, 8'h01);
    chk("held_data1", data_o, 8'h02);
    chk("held_valid1", {7'd0, valid_o}, 8'h01);
    tick();
    chk("held_reaccept_busy", {7'd0, busy_o}, 8'h01);
    chk("held_reaccept_valid", {7'd0, valid_o}, 8'h00);
    chk("held_reaccept_data", data_o, 8'h00);
    chk("held_reaccept_done", {7'd0, done_o}, 8'h00);
    start = 1'b0;
    tick();
    chk("held_done_low", {7'd0, done_o}, 8'h00);
    tick();
    chk("held_done2", {7'd0, done_o}, 8'h01);
    chk("held_data2", data_o, 8'h02);

    // Start and mask change while busy: ignored, one done, all 8 channels captured.
    mux_in = 8'h3C;
    pulse_start(8'hFF);
    done_cnt = 0;
    done_n   = -1;
    for (int n = 0; n < 20; n++) begin
      if (n == 4) begin
        start   = 1'b1;
        en_mask = 8'h01;
      end
      if (n == 5) start = 1'b0;
      if (done_o) begin
        done_cnt++;
        done_n = n;
      end
      if (n == 15) chk("busy_ign_busy15", {7'd0, busy_o}, 8'h01);
      tick();
    end
    chk("busy_ign_done_cnt", 8'(done_cnt), 8'd1);
    chk("busy_ign_done_at", 8'(done_n), 8'd16);
    chk("busy_ign_data", data_o, 8'h3C);
    chk("busy_ign_idle", {7'd0, busy_o}, 8'h00);

    // Reset mid-scan at S=3: immediate clear, no done, clean rescan afterwards.
    mux_in = 8'hA5;
    pulse_start(8'hFF);
    for (int n = 0; n < 6; n++) tick();
    chk("midrst_S3", {5'd0, s_o}, 8'h03);
    #2 rst = 1'b1;
    #1 chk_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (done_o || busy_o) done_cnt++;
      tick();
    end
    chk("midrst_quiet", 8'(done_cnt), 8'd0);
    chk("midrst_valid", {7'd0, valid_o}, 8'h00);
    mux_in = 8'h96;
    pulse_start(8'hFF);
    chk("rescan_S0", {5'd0, s_o}, 8'h00);
    chk("rescan_busy", {7'd0, busy_o}, 8'h01);
    for (int n = 0; n < 16; n++) tick();
    chk("rescan_done", {7'd0, done_o}, 8'h01);
    chk("rescan_data", data_o, 8'h96);
    chk("rescan_valid", {7'd0, valid_o}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
